// File: rtl/muldiv_unit_if.sv
// Request handshake between the execute stage and muldiv_unit.
// master: execute stage (req_valid/op/src1/src2 out, req_ready in); slave: muldiv_unit.
interface muldiv_unit_if #(
   parameter int WIDTH = 32
);
   logic             req_valid;
   logic             req_ready;
   logic [2:0]       req_op;
   logic [WIDTH-1:0] req_src1;
   logic [WIDTH-1:0] req_src2;

   modport master (
      output req_valid,
      output req_op,
      output req_src1,
      output req_src2,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  req_op,
      input  req_src1,
      input  req_src2,
      output req_ready
   );
endinterface

// File: rtl/muldiv_unit.sv
// Multiply/divide unit owning HI/LO: pipelined MUL/MULU, radix-2 restoring DIV/DIVU.
// Ports: clk, reset (sync, active-high), req (slave handshake), cancel (flush),
//        busy/done (registered status), hi/lo (HI/LO registers).
module muldiv_unit #(
   parameter int WIDTH   = 32,
   parameter int MUL_LAT = 2
) (
   input  logic             clk,
   input  logic             reset,
   muldiv_unit_if.slave     req,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH - 1);

   localparam logic [2:0] OP_MUL  = 3'd0;
   localparam logic [2:0] OP_MULU = 3'd1;
   localparam logic [2:0] OP_DIV  = 3'd2;
   localparam logic [2:0] OP_DIVU = 3'd3;
   localparam logic [2:0] OP_MTHI = 3'd4;
   localparam logic [2:0] OP_MTLO = 3'd5;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_FIX
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;

   logic [WIDTH:0]   mul_a;
   logic [WIDTH:0]   mul_b;

   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH:0]   rem;
   logic             neg_q;
   logic             neg_r;

   logic             accept;
   logic             src_signed;
   logic             s1_neg;
   logic             s2_neg;
   logic [WIDTH-1:0] mag1;
   logic [WIDTH-1:0] mag2;

   logic [2*WIDTH-1:0] ext_a;
   logic [2*WIDTH-1:0] ext_b;
   logic [2*WIDTH-1:0] prod;

   logic [WIDTH+1:0] rem_sh;
   logic [WIDTH+1:0] diff;
   logic             borrow;

   function automatic logic [WIDTH-1:0] neg(
      input logic [WIDTH-1:0] x
   );
      return ~x + WIDTH'(1);
   endfunction

   assign req.req_ready = (state == S_IDLE)
                        && !cancel && !reset;
   assign accept = req.req_valid && req.req_ready;

   assign src_signed = (req.req_op == OP_MUL)
                    || (req.req_op == OP_DIV);
   assign s1_neg = src_signed && req.req_src1[WIDTH-1];
   assign s2_neg = src_signed && req.req_src2[WIDTH-1];
   assign mag1   = s1_neg ? neg(req.req_src1) : req.req_src1;
   assign mag2   = s2_neg ? neg(req.req_src2) : req.req_src2;

   // Product modulo 2^(2W) of the sign-extended (W+1)-bit
   // operands is exactly the truncated 2W-bit result.
   assign ext_a = {{(WIDTH-1){mul_a[WIDTH]}}, mul_a};
   assign ext_b = {{(WIDTH-1){mul_b[WIDTH]}}, mul_b};
   assign prod  = ext_a * ext_b;

   // Shift the next dividend bit in; the extra top bit of
   // diff is the borrow of the trial subtraction.
   assign rem_sh = {rem, quo[WIDTH-1]};
   assign diff   = rem_sh - {2'b00, dvs};
   assign borrow = diff[WIDTH+1];

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         hi    <= '0;
         lo    <= '0;
         mul_a <= '0;
         mul_b <= '0;
         quo   <= '0;
         dvs   <= '0;
         rem   <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
      end else begin
         done <= 1'b0;
         if (cancel) begin
            state <= S_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
         end else begin
            unique case (state)
               S_IDLE: begin
                  if (accept) begin
                     cnt <= '0;
                     unique case (req.req_op)
                        OP_MUL, OP_MULU: begin
                           mul_a <= {s1_neg, req.req_src1};
                           mul_b <= {s2_neg, req.req_src2};
                           state <= S_MUL;
                           busy  <= 1'b1;
                        end
                        OP_DIV, OP_DIVU: begin
                           busy <= 1'b1;
                           if (req.req_src2 == '0) begin
                              // FIX passes these through
                              // unmodified: lo=~0, hi=src1.
                              quo   <= '1;
                              rem   <= {1'b0, req.req_src1};
                              neg_q <= 1'b0;
                              neg_r <= 1'b0;
                              state <= S_FIX;
                           end else begin
                              quo   <= mag1;
                              dvs   <= mag2;
                              rem   <= '0;
                              neg_q <= s1_neg ^ s2_neg;
                              neg_r <= s1_neg;
                              state <= S_DIV;
                           end
                        end
                        OP_MTHI: begin
                           hi   <= req.req_src1;
                           done <= 1'b1;
                        end
                        OP_MTLO: begin
                           lo   <= req.req_src1;
                           done <= 1'b1;
                        end
                        default: begin
                        end
                     endcase
                  end
               end
               S_MUL: begin
                  if (cnt == MUL_LAST) begin
                     hi    <= prod[2*WIDTH-1:WIDTH];
                     lo    <= prod[WIDTH-1:0];
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     cnt   <= '0;
                     state <= S_IDLE;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               S_DIV: begin
                  rem <= borrow ? rem_sh[WIDTH:0]
                                : diff[WIDTH:0];
                  quo <= {quo[WIDTH-2:0], ~borrow};
                  if (cnt == DIV_LAST) begin
                     cnt   <= '0;
                     state <= S_FIX;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               S_FIX: begin
                  lo    <= neg_q ? neg(quo) : quo;
                  hi    <= neg_r ? neg(rem[WIDTH-1:0])
                                 : rem[WIDTH-1:0];
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
               default: begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
